// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU front-end widths, reset PC and fetch entry type
package cpu_pkg;

    localparam int CPU_ADDR_W   = 7;
    localparam int CPU_DATA_W   = 32;
    localparam int CPU_RESET_PC = 0;

    typedef struct packed {
        logic [CPU_ADDR_W-1:0] pc;
        logic [CPU_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - prefetch FIFO with flush; head entry held in a register
module ifetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 39,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] cnt_after_pop;
    logic [WIDTH-1:0] head_next;
    logic             do_pop;
    logic             do_push;

    assign empty         = (count == '0);
    assign do_pop        = pop && !empty;
    assign rd_next       = rd_ptr + PTR_W'(do_pop);
    assign cnt_after_pop = count - CNT_W'(do_pop);
    assign do_push       = push && (cnt_after_pop != CNT_W'(DEPTH));

    // The head register only changes when a valid entry will sit at the head,
    // so an empty FIFO keeps presenting the last value.
    always_comb begin
        head_next = head_data;
        if (!flush) begin
            if (cnt_after_pop != '0) begin
                head_next = mem[rd_next];
            end else if (do_push) begin
                head_next = push_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            head_data <= '0;
        end else begin
            head_data <= head_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                wr_ptr <= wr_ptr + PTR_W'(do_push);
                rd_ptr <= rd_next;
                count  <= cnt_after_pop + CNT_W'(do_push);
            end
        end
    end

endmodule

// File: rtl/ifetch_stage.sv
// rtl/ifetch_stage.sv - instruction fetch stage with redirect flush; IFETCH_PERF_EN adds perf counters
module ifetch_stage
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = CPU_ADDR_W,
    parameter int DATA_W     = CPU_DATA_W,
    parameter int FIFO_DEPTH = 2,
    parameter int RESET_PC   = CPU_RESET_PC
) (
    input  logic              clka,
    input  logic              rst_n,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
`ifdef IFETCH_PERF_EN
    input  logic              out_ready,
    output logic [31:0]       perf_fetch_cnt,
    output logic [15:0]       perf_drop_cnt
`else
    input  logic              out_ready
`endif
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int USED_W = CNT_W + 1;

    logic [ADDR_W-1:0]        pc;
    logic [ADDR_W-1:0]        issued_pc;
    logic                     inflight;
    logic [CNT_W-1:0]         count;
    logic                     empty;
    logic                     pop;
    logic                     push;
    logic [USED_W-1:0]        used;
    logic [ADDR_W+DATA_W-1:0] head;

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    // A response arriving in a redirect cycle belongs to the old path.
    assign push      = inflight && !redirect_valid;

    // An entry popped this cycle frees its slot in time for the next push,
    // which keeps one fetch per cycle with a two-entry FIFO.
    assign used      = USED_W'(count) + USED_W'(inflight) - USED_W'(pop);
    assign imem_en   = rst_n && !redirect_valid && (used < USED_W'(FIFO_DEPTH));
    assign imem_addr = imem_en ? pc : '0;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= ADDR_W'(RESET_PC);
            issued_pc <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= imem_en;
            if (imem_en) begin
                issued_pc <= pc;
            end
            if (redirect_valid) begin
                pc <= redirect_pc;
            end else if (imem_en) begin
                pc <= pc + 1'b1;
            end
        end
    end

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk       (clka),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({issued_pc, imem_rdata}),
        .pop       (pop),
        .head_data (head),
        .count     (count),
        .empty     (empty)
    );

    assign out_pc    = head[ADDR_W+DATA_W-1:DATA_W];
    assign out_instr = head[DATA_W-1:0];

`ifdef IFETCH_PERF_EN
    logic [CNT_W-1:0] lost;
    logic [16:0]      drop_sum;

    // An entry handed to decode in the redirect cycle is consumed, not lost.
    assign lost     = redirect_valid ? (count - CNT_W'(pop)) : '0;
    assign drop_sum = {1'b0, perf_drop_cnt} + 17'(lost) + 17'(inflight && redirect_valid);

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            if (imem_en && (perf_fetch_cnt != '1)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
            end
            perf_drop_cnt <= drop_sum[16] ? '1 : drop_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// tb/tb_ifetch_stage.sv - scoreboard bench for ifetch_stage with a 1-cycle RAM model
module tb_ifetch_stage;
    import cpu_pkg::*;

    logic        clka = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_en;
    logic [6:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [6:0]  redirect_pc = '0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [6:0]  out_pc;
    logic        out_ready = 1'b0;

    logic [31:0]  ram [128];
    fetch_entry_t sb [$];
    int           n_vec = 0;
    int           n_err = 0;

    ifetch_stage dut (
        .clka           (clka),
        .rst_n          (rst_n),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    always #5 clka = ~clka;

    always @(posedge clka) begin
        if (imem_en) imem_rdata <= ram[imem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic fetch_entry_t mk(input logic [6:0] p);
        fetch_entry_t e;
        e.pc    = p;
        e.instr = 32'hA0 + 32'(p);
        return e;
    endfunction

    task automatic sb_fill(input logic [6:0] start, input int n);
        for (int i = 0; i < n; i++) sb.push_back(mk(start + 7'(i)));
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic redirect(input logic [6:0] tgt, input int n);
        fetch_entry_t keep;
        if (out_valid && out_ready && sb.size() > 0) begin
            keep = sb[0];
            sb.delete();
            sb.push_back(keep);
        end else begin
            sb.delete();
        end
        sb_fill(tgt, n);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        step();
        redirect_valid = 1'b0;
    endtask

    always @(negedge clka) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(out_pc), 64'h1FF);
            end else begin
                chk("out_pc", 64'(out_pc), 64'(sb[0].pc));
                chk("out_instr", 64'(out_instr), 64'(sb[0].instr));
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        int  fetches;
        bit  found;
        for (int i = 0; i < 128; i++) ram[i] = 32'hA0 + 32'(i);

        step();
        step();
        chk("rst_imem_en", 64'(imem_en), 64'd0);
        chk("rst_imem_addr", 64'(imem_addr), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);

        sb_fill(7'd0, 32);
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #1;
        chk("c0_imem_en", 64'(imem_en), 64'd1);
        chk("c0_addr", 64'(imem_addr), 64'd0);
        chk("c0_valid", 64'(out_valid), 64'd0);
        step();
        chk("c1_addr", 64'(imem_addr), 64'd1);
        chk("c1_valid", 64'(out_valid), 64'd0);
        step();
        chk("c2_valid", 64'(out_valid), 64'd1);
        chk("c2_pc", 64'(out_pc), 64'd0);
        chk("c2_addr", 64'(imem_addr), 64'd2);
        step();
        chk("c3_addr", 64'(imem_addr), 64'd3);
        chk("c3_pc", 64'(out_pc), 64'd1);
        for (int i = 0; i < 8; i++) step();

        out_ready = 1'b0;
        redirect(7'd5, 16);
        for (int i = 0; i < 5; i++) step();
        chk("hold5_valid", 64'(out_valid), 64'd1);
        chk("hold5_pc", 64'(out_pc), 64'd5);
        chk("hold5_imem_en", 64'(imem_en), 64'd0);

        redirect(7'h40, 16);
        chk("r40_flush", 64'(out_valid), 64'd0);
        step();
        chk("r40_c1", 64'(out_valid), 64'd0);
        step();
        chk("r40_c2_valid", 64'(out_valid), 64'd1);
        chk("r40_c2_pc", 64'(out_pc), 64'h40);
        chk("r40_c2_instr", 64'(out_instr), 64'hE0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        redirect(7'd8, 16);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (out_valid && out_pc == 7'd9) found = 1'b1;
            else step();
        end
        chk("wait_pc9", 64'(found), 64'd1);
        redirect(7'h7F, 16);
        step();
        chk("r7f_c1", 64'(out_valid), 64'd0);
        step();
        chk("r7f_c2_valid", 64'(out_valid), 64'd1);
        chk("r7f_c2_pc", 64'(out_pc), 64'h7F);
        step();
        chk("wrap_pc", 64'(out_pc), 64'h00);
        chk("wrap_instr", 64'(out_instr), 64'hA0);
        for (int i = 0; i < 3; i++) step();

        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_imem_en", 64'(imem_en), 64'd0);
        chk("arst_pc", 64'(out_pc), 64'd0);
        out_ready = 1'b0;
        sb.delete();
        sb_fill(7'd0, 16);
        step();
        step();
        rst_n   = 1'b1;
        fetches = 0;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (imem_en) fetches++;
            step();
        end
        chk("stall_fetches", 64'(fetches), 64'd2);
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_pc", 64'(out_pc), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("sb_drained", 64'(sb.size() < 16), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
